// File: rtl/round_const_lfsr_seq.sv
// Round-constant sequencer: Fibonacci LFSR stepped forward or backward under a start/step/done handshake.
// Optional registered parity output rc_par is built when RC_PARITY_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; rc and round_idx hold
// RUN   | stepping constants on step until the final round completes
module round_const_lfsr_seq #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = 8'b01100011,
  parameter logic [WIDTH-1:0] SEED   = 8'h36,
  parameter int               ROUNDS = 16,
  parameter int               CNT_W  = $clog2(ROUNDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             step,
  input  logic             abort,
  output logic [WIDTH-1:0] rc,
  output logic [CNT_W-1:0] round_idx,
  output logic             busy,
  output logic             first_round,
  output logic             last_round,
  output logic             done
`ifdef RC_PARITY_EN
  ,
  output logic             rc_par
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [WIDTH-1:0] lfsr_fwd(input logic [WIDTH-1:0] s);
    return {^(s & TAPS), s[WIDTH-1:1]};
  endfunction

  // TAPS[0] is set, so the bit shifted out can be recovered from the new MSB.
  function automatic logic [WIDTH-1:0] lfsr_rev(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], s[WIDTH-1] ^ (^(s[WIDTH-2:0] & TAPS[WIDTH-1:1]))};
  endfunction

  function automatic logic [WIDTH-1:0] calc_last_state();
    logic [WIDTH-1:0] s;
    s = SEED;
    for (int i = 0; i < ROUNDS - 1; i++) s = lfsr_fwd(s);
    return s;
  endfunction

  localparam logic [WIDTH-1:0] LAST_STATE = calc_last_state();
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(ROUNDS - 1);

  state_t           state;
  logic             dir_q;
  logic [WIDTH-1:0] rc_nxt;
  logic             at_last;

  assign at_last     = (round_idx == LAST_IDX);
  assign busy        = (state == RUN);
  assign first_round = busy && (round_idx == '0);
  assign last_round  = busy && at_last;

  always_comb begin
    rc_nxt = rc;
    case (state)
      IDLE: if (start) rc_nxt = dir ? LAST_STATE : SEED;
      RUN:  if (!abort && step && !at_last) rc_nxt = dir_q ? lfsr_rev(rc) : lfsr_fwd(rc);
      default: rc_nxt = rc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rc        <= SEED;
      round_idx <= '0;
      dir_q     <= 1'b0;
      done      <= 1'b0;
`ifdef RC_PARITY_EN
      rc_par    <= ^SEED;
`endif
    end else begin
      done <= 1'b0;
      rc   <= rc_nxt;
`ifdef RC_PARITY_EN
      rc_par <= ^rc_nxt;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            round_idx <= '0;
            dir_q     <= dir;
            state     <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            round_idx <= '0;
            state     <= IDLE;
          end else if (step) begin
            if (at_last) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              round_idx <= round_idx + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
